pipe_serializer: RTL and testbench
==================================

Name: pipe_serializer

Overview:
- Sequences instructions that must execute alone in the pipeline: CSR access, FENCE and FENCE.I.
- Replaces the blanket per-stage CSR stall with an explicit drain → issue → retire → (invalidate/refetch) state machine.
- Sits beside the hazard detect unit. Its stall and bubble outputs are ORed into the IF/ID stall and ID flush terms.
- For FENCE.I it drives the I-cache invalidate handshake and requests a refetch of the next PC.

Parameters:
- TIMEOUT_W, 8: width of the watchdog counter (used only with the optional feature).
- TIMEOUT_MAX, 255: cycle count in any non-IDLE state that triggers a watchdog timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_serial  in  1  ID instruction needs serialization
- id_serial_type  in  2  0=CSR, 1=FENCE, 2=FENCE.I, 3=reserved (treated as CSR)
- ex_valid, mem_valid, wb_valid  in  1 each  downstream stage occupancy
- lsu_busy  in  1  outstanding data-bus transaction
- take_branch  in  1  branch/jump redirect from EX
- trap_flush  in  1  trap/mret pipeline flush
- wb_serial_retire  in  1  serialized instruction retires in WB this cycle
- icache_inv_done  in  1  I-cache invalidate complete
- ser_stall  out  1  hold IF/ID
- ser_bubble  out  1  insert bubble into EX
- icache_inv  out  1  invalidate request, level, held until done
- refetch  out  1  one-cycle pulse: redirect fetch to PC+4 of the FENCE.I
- ser_busy  out  1  FSM not in IDLE
- ser_timeout  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Reset: FSM = IDLE; all outputs 0; latched type = CSR; watchdog = 0.
- Only ser_stall and ser_bubble are combinational from state plus inputs. icache_inv, refetch and ser_busy are registered.
- IDLE:
  - Outputs 0.
  - If id_valid & id_serial & ~take_branch & ~trap_flush: latch type; ser_stall=1 and ser_bubble=1 in the same cycle; go to DRAIN.
- DRAIN:
  - ser_stall=1, ser_bubble=1.
  - When ex_valid, mem_valid, wb_valid and lsu_busy are all 0, go to ISSUE.
  - An all-clear in the entry cycle still costs one DRAIN cycle.
- ISSUE:
  - Exactly one cycle; ser_stall=0, ser_bubble=0, so the instruction moves to EX.
  - Next state WAIT.
- WAIT:
  - ser_stall=1, ser_bubble=1.
  - On wb_serial_retire: go to INV if type=FENCE.I, else IDLE.
  - FENCE additionally requires lsu_busy=0 in the same cycle as retire; otherwise remain in WAIT until both hold.
- INV:
  - icache_inv=1, ser_stall=1.
  - On icache_inv_done, go to REFETCH; icache_inv drops on the next edge.
- REFETCH:
  - refetch=1 for one cycle, ser_stall=1; return to IDLE.
- Abort:
  - take_branch in DRAIN or ISSUE means an older instruction redirects, so the serialized instruction is squashed: go to IDLE next cycle, no refetch.
  - trap_flush in DRAIN, ISSUE or WAIT: go to IDLE.
  - trap_flush in INV: remain until icache_inv_done (the invalidate is never cut short), then IDLE without refetch.
  - Abort has priority over every other transition in the same cycle.
- Back-to-back: returning to IDLE with another serial instruction already in ID re-enters DRAIN on the following cycle. There is no same-cycle chaining.
- ser_busy = (state != IDLE), registered.
- Reset asserted mid-sequence drops icache_inv immediately and asynchronously. The I-cache must tolerate an aborted invalidate.

Optional Feature:
- Macro: PIPE_SERIALIZER_WATCHDOG_EN.
- With the macro:
  - A TIMEOUT_W-bit counter clears on every state change and increments in each non-IDLE cycle.
  - Reaching TIMEOUT_MAX sets ser_timeout (sticky until rst) and forces the FSM to IDLE, releasing the stall.
- Without the macro: the counter is absent, ser_timeout is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Shared package core.vh: state encodings (SER_IDLE, SER_DRAIN, SER_ISSUE, SER_WAIT, SER_INV, SER_REFETCH; 3-bit) and serial-type constants (SER_CSR, SER_FENCE, SER_FENCEI).
- decoder.vh already produces id_serial and id_serial_type; the decoder owns that mapping.
- Sub-module: none required. The watchdog may be a small ser_watchdog counter instance, compiled only under the macro.

Test Plan:
- CSR with empty pipeline: id_serial=1, type=0, all valids 0 → DRAIN 1 cycle, ISSUE cycle with ser_stall=0, WAIT; wb_serial_retire 3 cycles later → IDLE; ser_stall high for exactly 5 cycles in total.
- FENCE with a store in flight: mem_valid=1 for 2 cycles, then lsu_busy=1 for 4 more cycles → ISSUE only after lsu_busy=0. Retire arriving while lsu_busy=1 → stays in WAIT until lsu_busy=0.
- FENCE.I full sequence: retire → icache_inv=1; icache_inv_done after 10 cycles → one-cycle refetch pulse → IDLE.
- Branch abort: take_branch=1 in the second DRAIN cycle → IDLE next cycle, ser_stall=0, refetch never asserted.
- Trap during INV: trap_flush=1 while icache_inv=1 → icache_inv held until done, then IDLE with no refetch.
- Watchdog (macro defined, TIMEOUT_MAX=16): wb_valid held 1 forever → ser_timeout=1 after 16 DRAIN cycles, FSM returns to IDLE; without the macro → remains in DRAIN and ser_timeout stays 0.

Source files
------------

// File: rtl/pipe_serializer_pkg.sv
// Shared encodings for the pipeline serializer: FSM states, serial instruction
// classes and the decode of the ID-stage serial type field.
package pipe_serializer_pkg;

    localparam int SER_TIMEOUT_W_DEFAULT   = 8;
    localparam int SER_TIMEOUT_MAX_DEFAULT = 255;

    typedef enum logic [2:0] {
        SER_IDLE    = 3'd0,
        SER_DRAIN   = 3'd1,
        SER_ISSUE   = 3'd2,
        SER_WAIT    = 3'd3,
        SER_INV     = 3'd4,
        SER_REFETCH = 3'd5
    } ser_state_e;

    typedef enum logic [1:0] {
        SER_CSR    = 2'd0,
        SER_FENCE  = 2'd1,
        SER_FENCEI = 2'd2
    } ser_type_e;

    // Encoding 3 is reserved by the decoder and handled like a CSR access.
    function automatic ser_type_e decode_ser_type(input logic [1:0] raw);
        ser_type_e t;
        case (raw)
            2'd1:    t = SER_FENCE;
            2'd2:    t = SER_FENCEI;
            default: t = SER_CSR;
        endcase
        return t;
    endfunction

    function automatic logic pipe_drained(input logic ex_v, input logic mem_v,
                                          input logic wb_v, input logic lsu_b);
        return ~(ex_v | mem_v | wb_v | lsu_b);
    endfunction

endpackage

// File: rtl/pipe_serializer.sv
// Drain/issue/retire/invalidate sequencer for CSR, FENCE and FENCE.I.
// Optional watchdog enabled with `define PIPE_SERIALIZER_WATCHDOG_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------
// SER_IDLE    | no serial instruction in flight; entry decided on ID inputs
// SER_DRAIN   | ID held, bubbles into EX until EX/MEM/WB/LSU are empty
// SER_ISSUE   | one cycle: the serial instruction advances into EX
// SER_WAIT    | ID held until the serial instruction retires in WB
// SER_INV     | FENCE.I: I-cache invalidate requested, waiting for done
// SER_REFETCH | FENCE.I: one-cycle redirect of fetch to the next PC
module pipe_serializer
    import pipe_serializer_pkg::*;
#(
    parameter int TIMEOUT_W   = SER_TIMEOUT_W_DEFAULT,
    parameter int TIMEOUT_MAX = SER_TIMEOUT_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_serial,
    input  logic [1:0] id_serial_type,
    input  logic       ex_valid,
    input  logic       mem_valid,
    input  logic       wb_valid,
    input  logic       lsu_busy,
    input  logic       take_branch,
    input  logic       trap_flush,
    input  logic       wb_serial_retire,
    input  logic       icache_inv_done,
    output logic       ser_stall,
    output logic       ser_bubble,
    output logic       icache_inv,
    output logic       refetch,
    output logic       ser_busy,
    output logic       ser_timeout
);

    ser_state_e state_q, state_d, fsm_next;
    ser_type_e  type_q, type_d;
    logic       retired_q, retired_d;
    logic       trap_seen_q, trap_seen_d;
    logic       icache_inv_q, icache_inv_d;
    logic       refetch_q, refetch_d;
    logic       ser_busy_q, ser_busy_d;
    logic       start;
    logic       all_clear;
    logic       retire_seen;
    logic       wd_expire;

    assign start     = id_valid & id_serial & ~take_branch & ~trap_flush;
    assign all_clear = pipe_drained(ex_valid, mem_valid, wb_valid, lsu_busy);

    always_comb begin
        fsm_next    = state_q;
        type_d      = type_q;
        retired_d   = retired_q;
        trap_seen_d = trap_seen_q;
        retire_seen = 1'b0;
        ser_stall   = 1'b0;
        ser_bubble  = 1'b0;
        case (state_q)
            SER_IDLE: begin
                retired_d   = 1'b0;
                trap_seen_d = 1'b0;
                if (start) begin
                    type_d     = decode_ser_type(id_serial_type);
                    ser_stall  = 1'b1;
                    ser_bubble = 1'b1;
                    fsm_next   = SER_DRAIN;
                end
            end
            SER_DRAIN: begin
                ser_stall  = 1'b1;
                ser_bubble = 1'b1;
                if (take_branch || trap_flush) begin
                    fsm_next = SER_IDLE;
                end else if (all_clear) begin
                    fsm_next = SER_ISSUE;
                end
            end
            SER_ISSUE: begin
                if (take_branch || trap_flush) begin
                    fsm_next = SER_IDLE;
                end else begin
                    fsm_next = SER_WAIT;
                end
            end
            SER_WAIT: begin
                ser_stall  = 1'b1;
                ser_bubble = 1'b1;
                // A FENCE retire seen while the LSU is still busy is remembered
                // so the sequence can finish once the bus goes idle.
                retire_seen = wb_serial_retire | retired_q;
                if (trap_flush) begin
                    fsm_next = SER_IDLE;
                end else if (retire_seen) begin
                    retired_d = 1'b1;
                    case (type_q)
                        SER_FENCEI: fsm_next = SER_INV;
                        SER_FENCE:  if (!lsu_busy) fsm_next = SER_IDLE;
                        default:    fsm_next = SER_IDLE;
                    endcase
                end
            end
            SER_INV: begin
                ser_stall = 1'b1;
                if (trap_flush) begin
                    trap_seen_d = 1'b1;
                end
                if (icache_inv_done) begin
                    fsm_next = (trap_seen_q || trap_flush) ? SER_IDLE : SER_REFETCH;
                end
            end
            SER_REFETCH: begin
                ser_stall = 1'b1;
                fsm_next  = SER_IDLE;
            end
            default: begin
                fsm_next = SER_IDLE;
            end
        endcase
    end

    always_comb begin
        state_d = fsm_next;
        if (wd_expire) begin
            state_d = SER_IDLE;
        end
    end

    assign icache_inv_d = (state_d == SER_INV);
    assign refetch_d    = (state_d == SER_REFETCH);
    assign ser_busy_d   = (state_d != SER_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SER_IDLE;
            type_q       <= SER_CSR;
            retired_q    <= 1'b0;
            trap_seen_q  <= 1'b0;
            icache_inv_q <= 1'b0;
            refetch_q    <= 1'b0;
            ser_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            retired_q    <= retired_d;
            trap_seen_q  <= trap_seen_d;
            icache_inv_q <= icache_inv_d;
            refetch_q    <= refetch_d;
            ser_busy_q   <= ser_busy_d;
        end
    end

    assign icache_inv = icache_inv_q;
    assign refetch    = refetch_q;
    assign ser_busy   = ser_busy_q;

`ifdef PIPE_SERIALIZER_WATCHDOG_EN
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_MAX);

    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d, wd_cnt_inc;
    logic                 ser_timeout_q, ser_timeout_d;

    assign wd_cnt_inc = wd_cnt_q + 1'b1;
    assign wd_expire  = (state_q != SER_IDLE) && (wd_cnt_inc == WD_LIMIT);

    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        ser_timeout_d = ser_timeout_q | wd_expire;
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (state_q != SER_IDLE) begin
            wd_cnt_d = wd_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            ser_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            ser_timeout_q <= ser_timeout_d;
        end
    end

    assign ser_timeout = ser_timeout_q;
`else
    logic unused_wd_cfg;

    assign unused_wd_cfg = (TIMEOUT_W > 0) && (TIMEOUT_MAX > 0);
    assign wd_expire     = 1'b0;
    assign ser_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_serializer.sv
// Cycle-accurate scoreboard bench for pipe_serializer; every cycle checks
// {ser_stall, ser_bubble, icache_inv, refetch, ser_busy, ser_timeout}.
module tb_pipe_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_serial;
    logic [1:0] id_serial_type;
    logic       ex_valid, mem_valid, wb_valid, lsu_busy;
    logic       take_branch, trap_flush, wb_serial_retire, icache_inv_done;
    logic       ser_stall, ser_bubble, icache_inv, refetch, ser_busy, ser_timeout;
    logic [5:0] obs;

    int total = 0;
    int bad   = 0;

    logic [11:0] plan_in_q[$];
    logic [5:0]  plan_exp_q[$];
    logic [5:0]  sb_q[$];

    // stimulus bits: idv ids typ[1:0] ex mem wb lsu br trap ret done
    localparam logic [11:0] ID_CSR   = 12'b1100_0000_0000;
    localparam logic [11:0] ID_FENCE = 12'b1101_0000_0000;
    localparam logic [11:0] ID_FENCI = 12'b1110_0000_0000;
    localparam logic [11:0] ID_RSV   = 12'b1111_0000_0000;
    localparam logic [11:0] EX   = 12'h080;
    localparam logic [11:0] MEM  = 12'h040;
    localparam logic [11:0] WB   = 12'h020;
    localparam logic [11:0] LSU  = 12'h010;
    localparam logic [11:0] BR   = 12'h008;
    localparam logic [11:0] TRAP = 12'h004;
    localparam logic [11:0] RET  = 12'h002;
    localparam logic [11:0] DONE = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    // expected bits: stall bubble inv refetch busy timeout
    localparam logic [5:0] E_IDLE  = 6'b000000;
    localparam logic [5:0] E_START = 6'b110000;
    localparam logic [5:0] E_HOLD  = 6'b110010;
    localparam logic [5:0] E_ISSUE = 6'b000010;
    localparam logic [5:0] E_INV   = 6'b101010;
    localparam logic [5:0] E_REF   = 6'b100110;

    pipe_serializer #(.TIMEOUT_W(8), .TIMEOUT_MAX(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_serial        (id_serial),
        .id_serial_type   (id_serial_type),
        .ex_valid         (ex_valid),
        .mem_valid        (mem_valid),
        .wb_valid         (wb_valid),
        .lsu_busy         (lsu_busy),
        .take_branch      (take_branch),
        .trap_flush       (trap_flush),
        .wb_serial_retire (wb_serial_retire),
        .icache_inv_done  (icache_inv_done),
        .ser_stall        (ser_stall),
        .ser_bubble       (ser_bubble),
        .icache_inv       (icache_inv),
        .refetch          (refetch),
        .ser_busy         (ser_busy),
        .ser_timeout      (ser_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {ser_stall, ser_bubble, icache_inv, refetch, ser_busy, ser_timeout};

    task automatic apply(input logic [11:0] v);
        {id_valid, id_serial, id_serial_type, ex_valid, mem_valid, wb_valid, lsu_busy,
         take_branch, trap_flush, wb_serial_retire, icache_inv_done} = v;
    endtask

    task automatic plan(input logic [11:0] v, input logic [5:0] e);
        plan_in_q.push_back(v);
        plan_exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(NONE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== E_IDLE) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", obs, E_IDLE);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_csr();
        logic [5:0] e;
        int stall_cnt = 0;
        int cyc = 0;
        plan(ID_CSR, E_START);
        plan(ID_CSR, E_HOLD);
        plan(ID_CSR, E_ISSUE);
        plan(EX, E_HOLD);
        plan(MEM, E_HOLD);
        plan(WB | RET, E_HOLD);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            stall_cnt += int'(ser_stall);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL csr cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
        total++;
        if (stall_cnt != 5) begin
            bad++;
            $display("FAIL csr_stall_cycles got=%0d exp=5", stall_cnt);
        end
    endtask

    task automatic test_fence();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_FENCE | MEM, E_START);
        plan(ID_FENCE | MEM, E_HOLD);
        for (int i = 0; i < 4; i++) plan(ID_FENCE | LSU, E_HOLD);
        plan(ID_FENCE, E_HOLD);
        plan(ID_FENCE, E_ISSUE);
        plan(LSU, E_HOLD);
        plan(LSU | RET, E_HOLD);
        plan(LSU, E_HOLD);
        plan(NONE, E_HOLD);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fence cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_fencei();
        logic [5:0] e;
        int ref_cnt = 0;
        int cyc = 0;
        plan(ID_FENCI, E_START);
        plan(ID_FENCI, E_HOLD);
        plan(ID_FENCI, E_ISSUE);
        plan(WB | RET, E_HOLD);
        for (int i = 0; i < 10; i++) plan(NONE, E_INV);
        plan(DONE, E_INV);
        plan(NONE, E_REF);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            ref_cnt += int'(refetch);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fencei cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
        total++;
        if (ref_cnt != 1) begin
            bad++;
            $display("FAIL fencei_refetch_pulses got=%0d exp=1", ref_cnt);
        end
    endtask

    task automatic test_branch_abort();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_CSR | WB, E_START);
        plan(ID_CSR | WB, E_HOLD);
        plan(WB | BR, E_HOLD);
        plan(NONE, E_IDLE);
        plan(ID_CSR, E_START);
        plan(ID_CSR, E_HOLD);
        plan(BR, E_ISSUE);
        plan(NONE, E_IDLE);
        plan(ID_CSR | BR, E_IDLE);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL branch_abort cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_trap();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_CSR | EX, E_START);
        plan(TRAP | EX, E_HOLD);
        plan(NONE, E_IDLE);
        plan(ID_FENCI, E_START);
        plan(ID_FENCI, E_HOLD);
        plan(NONE, E_ISSUE);
        plan(RET | TRAP, E_HOLD);
        plan(NONE, E_IDLE);
        plan(ID_FENCI, E_START);
        plan(NONE, E_HOLD);
        plan(NONE, E_ISSUE);
        plan(RET, E_HOLD);
        plan(TRAP, E_INV);
        plan(NONE, E_INV);
        plan(DONE, E_INV);
        plan(NONE, E_IDLE);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL trap cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_RSV, E_START);
        plan(ID_RSV, E_HOLD);
        plan(ID_RSV, E_ISSUE);
        plan(ID_FENCE | RET, E_HOLD);
        plan(ID_FENCE, E_START);
        plan(ID_FENCE, E_HOLD);
        plan(ID_FENCE, E_ISSUE);
        plan(RET, E_HOLD);
        plan(NONE, E_IDLE);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_FENCI, E_START);
        plan(NONE, E_HOLD);
        plan(NONE, E_ISSUE);
        plan(RET, E_HOLD);
        plan(NONE, E_INV);
        plan(NONE, E_INV);
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL async_reset_seq cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            bad++;
            $display("FAIL async_reset_drop got=%b exp=%b", obs, E_IDLE);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== E_IDLE) begin
            bad++;
            $display("FAIL async_reset_after got=%b exp=%b", obs, E_IDLE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_watchdog();
        logic [5:0] e;
        int cyc = 0;
        plan(ID_CSR | WB, E_START);
`ifdef PIPE_SERIALIZER_WATCHDOG_EN
        for (int i = 0; i < 16; i++) plan(WB, E_HOLD);
        plan(WB, 6'b000001);
        plan(NONE, 6'b000001);
`else
        for (int i = 0; i < 20; i++) plan(WB, E_HOLD);
        plan(WB | TRAP, E_HOLD);
        plan(NONE, E_IDLE);
`endif
        while (plan_in_q.size() != 0) begin
            apply(plan_in_q.pop_front());
            sb_q.push_back(plan_exp_q.pop_front());
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL watchdog cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_csr();
        test_fence();
        test_fencei();
        test_branch_abort();
        test_trap();
        test_back_to_back();
        test_async_reset();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
